// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-FF synchronizer, false-start rejection, 3-sample
// majority per bit, framing-error / break handling. Emits byte + 1-cycle strobe.
module uart_rx_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_stb,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_SAMP0 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_SAMP1 = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_DEC   = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q;
    logic             rx_meta_q;
    logic             rx_s_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bitidx_q;
    logic [7:0]       shreg_q;
    logic             samp0_q;
    logic             samp1_q;
    logic [7:0]       data_q;
    logic             stb_q;
    logic             ferr_q;
    logic             busy_q;

    logic bit_c;
    logic decide_c;
    logic last_c;

    // Majority of the two stored mid-bit samples and the live one at the decision point
    assign bit_c    = (samp0_q & samp1_q) | (samp0_q & rx_s_q) | (samp1_q & rx_s_q);
    assign decide_c = (cnt_q == CNT_DEC);
    assign last_c   = (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            cnt_q     <= '0;
            bitidx_q  <= '0;
            shreg_q   <= '0;
            samp0_q   <= 1'b0;
            samp1_q   <= 1'b0;
            data_q    <= '0;
            stb_q     <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            stb_q     <= 1'b0;
            ferr_q    <= 1'b0;

            if (cnt_q == CNT_SAMP0) samp0_q <= rx_s_q;
            if (cnt_q == CNT_SAMP1) samp1_q <= rx_s_q;

            case (state_q)
                S_IDLE: begin
                    // Detect cycle is cnt 0 of the start bit
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                S_START: begin
                    if (decide_c && bit_c) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (last_c) begin
                        cnt_q    <= '0;
                        bitidx_q <= '0;
                        state_q  <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (decide_c) shreg_q <= {bit_c, shreg_q[7:1]};
                    if (last_c) begin
                        cnt_q    <= '0;
                        bitidx_q <= bitidx_q + 3'(1);
                        if (bitidx_q == 3'd7) state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    // Resolve at mid stop bit so back-to-back frames keep half a bit of margin
                    if (decide_c) begin
                        if (bit_c) begin
                            data_q  <= shreg_q;
                            stb_q   <= 1'b1;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_data      = data_q;
    assign o_stb       = stb_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = busy_q;

endmodule
